dual_dac_serializer: RTL

- Output stage downstream of the low-pass and high-pass IIR filter pair.
- Captures both 32-bit sign-magnitude filter outputs on a sample strobe and converts each to a saturated 16-bit DAC code.
- Buffers the code pairs in a small FIFO.
- Shifts each pair out as one 32-bit SPI frame to a dual-channel DAC.

---
 rtl/dac_pkg.sv | 25 ++
 rtl/dual_dac_serializer_if.sv | 25 ++
 rtl/dual_dac_serializer_sync_fifo.sv | 53 +++++
 rtl/dual_dac_serializer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the dual DAC output stage.
// Contents: code/frame widths, the serializer state enum, and the
// sign-magnitude to saturated 16-bit two's-complement code conversion.
package dac_pkg;

    localparam int DAC_W   = 16;
    localparam int FRAME_W = 32;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_t;

    // x: bit31 sign, bits30:0 magnitude. The magnitude is scaled down by
    // 'shift', then clamped to the 16-bit range. The negative side clamps
    // at 32768, so full-scale negative maps to 0x8000. Negative zero maps to 0.
    function automatic logic [DAC_W-1:0] sm_to_code(input logic [31:0] x, input int shift);
        logic [30:0]      mag;
        logic [DAC_W-1:0] code;
        mag = x[30:0] >> shift;
        if (!x[31])
            code = (mag > 31'd32767) ? 16'h7FFF : mag[15:0];
        else
            code = (mag >= 31'd32768) ? 16'h8000 : 16'(~mag[15:0] + 16'd1);
        return code;
    endfunction

endpackage

// File: rtl/dual_dac_serializer_if.sv
// Bus bundle for dual_dac_serializer.
// master: sample producer / DAC side observer (drives sample_valid, low_pass,
//         high_pass; sees the SPI lines and status).
// slave : the serializer (drives sclk, cs_n, mosi, busy, overflow, fifo_level).
interface dual_dac_serializer_if #(parameter int DEPTH = 4) ();
    logic                     sample_valid;
    logic [31:0]              low_pass;
    logic [31:0]              high_pass;
    logic                     sclk;
    logic                     cs_n;
    logic                     mosi;
    logic                     busy;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   fifo_level;

    modport master (
        output sample_valid, low_pass, high_pass,
        input  sclk, cs_n, mosi, busy, overflow, fifo_level
    );

    modport slave (
        input  sample_valid, low_pass, high_pass,
        output sclk, cs_n, mosi, busy, overflow, fifo_level
    );
endinterface

// File: rtl/dual_dac_serializer_sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-2 depth, async active-high reset.
// Ports: push/din write, pop/dout read (dout shows the head entry),
//        full, empty, level = occupancy.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dual_dac_serializer.sv
// dual_dac_serializer: converts the low/high-pass filter outputs to 16-bit
// DAC codes, queues code pairs and shifts each pair out as one 32-bit SPI
// frame {codeA, codeB}, MSB first, sclk idle low, DAC samples on sclk rise.
// Ports: clk, rst (async, active high), bus (slave modport: sample_valid,
//        low_pass, high_pass in; sclk, cs_n, mosi, busy, overflow,
//        fifo_level out).
// Build option: define DAC_OFFSET_BINARY_EN to send offset-binary codes
// (MSB of each code inverted) instead of two's complement.
module dual_dac_serializer
    import dac_pkg::*;
#(
    parameter int SHIFT   = 8,
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    dual_dac_serializer_if.slave bus
);
    localparam int DIV_W = $clog2(2*CLK_DIV);
    localparam int BIT_W = $clog2(FRAME_W) + 1;
    localparam logic [DIV_W-1:0] HALF_END = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_END  = DIV_W'(2*CLK_DIV - 1);

    // conversion register
    logic [DAC_W-1:0]   code_a, code_b;
    logic               conv_vld;
    logic [FRAME_W-1:0] conv_pair;

    always_comb begin
        code_a = sm_to_code(bus.low_pass, SHIFT);
        code_b = sm_to_code(bus.high_pass, SHIFT);
`ifdef DAC_OFFSET_BINARY_EN
        code_a[DAC_W-1] = ~code_a[DAC_W-1];
        code_b[DAC_W-1] = ~code_b[DAC_W-1];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_vld  <= 1'b0;
            conv_pair <= '0;
        end else begin
            conv_vld <= bus.sample_valid;
            if (bus.sample_valid) conv_pair <= {code_a, code_b};
        end
    end

    // pair FIFO
    logic                   pop, full, empty;
    logic [FRAME_W-1:0]     fifo_dout;
    logic [$clog2(DEPTH):0] level;

    sync_fifo #(.WIDTH(FRAME_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (conv_vld),
        .din   (conv_pair),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    logic overflow;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           overflow <= 1'b0;
        else if (conv_vld && full && !pop) overflow <= 1'b1;
    end

    // SPI framer
    state_t             state, state_n;
    logic [FRAME_W-1:0] sr, sr_n;
    logic [DIV_W-1:0]   div, div_n;
    logic [BIT_W-1:0]   bit_cnt, bit_n;
    logic               sclk_q, sclk_n, cs_q, cs_n_n, mosi_q, mosi_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            sr      <= '0;
            div     <= '0;
            bit_cnt <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            div     <= div_n;
            bit_cnt <= bit_n;
            sclk_q  <= sclk_n;
            cs_q    <= cs_n_n;
            mosi_q  <= mosi_n;
        end
    end

    always_comb begin
        state_n = state;
        sr_n    = sr;
        div_n   = div;
        bit_n   = bit_cnt;
        sclk_n  = sclk_q;
        cs_n_n  = cs_q;
        mosi_n  = mosi_q;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sr_n    = fifo_dout;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cs_n_n  = 1'b0;
                mosi_n  = sr[FRAME_W-1];
                sr_n    = {sr[FRAME_W-2:0], 1'b0};
                div_n   = '0;
                bit_n   = '0;
                sclk_n  = 1'b0;
                state_n = ST_SHIFT;
            end
            ST_SHIFT: begin
                // one settle cycle after the last falling edge before cs_n rises
                if (bit_cnt == BIT_W'(FRAME_W)) begin
                    cs_n_n  = 1'b1;
                    mosi_n  = 1'b0;
                    div_n   = '0;
                    state_n = ST_GAP;
                end else if (div == HALF_END) begin
                    div_n  = '0;
                    sclk_n = ~sclk_q;
                    if (sclk_q) begin
                        mosi_n = sr[FRAME_W-1];
                        sr_n   = {sr[FRAME_W-2:0], 1'b0};
                        bit_n  = bit_cnt + 1'b1;
                    end
                end else begin
                    div_n = div + 1'b1;
                end
            end
            ST_GAP: begin
                if (div == GAP_END) begin
                    div_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    div_n = div + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.sclk       = sclk_q;
    assign bus.cs_n       = cs_q;
    assign bus.mosi       = mosi_q;
    assign bus.busy       = (state != ST_IDLE) || !empty;
    assign bus.overflow   = overflow;
    assign bus.fifo_level = level;

endmodule
